slave_reg_responder: RTL
========================

# slave_reg_responder

Sequential responder for the slv_* valid/ready bus, the target end of the bundle that the bus master drives. It holds a 16-entry × 4-bit register file. It accepts one read or write per transaction, inserts optional wait states, and returns a single-cycle ready pulse with read data. It sits under a top-level bundle module, wired port-for-port to a master's mst_* signals, and exports a completed-transaction count on bus_out.

## Interface
- WAIT_CYC, default 2: wait states inserted between acceptance and response; legal range 0..15. Used only when SLAVE_REG_WAIT_EN is defined.
- ID_VAL, default 4'ha: constant returned on a read of address 4'hf.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- slv_valid  input  1  request valid; held high by the master until it sees slv_ready.
- slv_we  input  1  1 = write, 0 = read; sampled at acceptance.
- slv_addr  input  4  register index; sampled at acceptance.
- slv_wdata  input  4  write data; sampled at acceptance.
- slv_rdata  output  4  response data; meaningful only while slv_ready is high.
- slv_ready  output  1  single-cycle response pulse.
- bus_out  output  5  count of completed transactions, modulo 32.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. All outputs are registered.
- IDLE to WAIT or RESP: taken at a rising edge when slv_valid is 1. This edge is acceptance.
  - At acceptance the block latches slv_we, slv_addr and slv_wdata.
  - The next state is WAIT if WAIT_CYC > 0 and the macro is defined; otherwise RESP.
- WAIT: a 4-bit counter loads WAIT_CYC-1 at acceptance and decrements each cycle. The FSM goes to RESP when the counter is 0.
- RESP: slv_ready = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- Write, addr 0..14: reg[addr] is updated with wdata on the edge that enters RESP. slv_rdata echoes the written wdata.
- Write, addr 15: the register file is unchanged. slv_rdata = ID_VAL.
- Read, addr 0..14: slv_rdata = reg[addr], sampled at the edge that enters RESP.
- Read, addr 15: slv_rdata = ID_VAL.
- bus_out increments on the edge leaving RESP and wraps from 31 to 0.
- slv_valid is ignored in WAIT and RESP. If slv_valid drops during WAIT, the transaction still completes and ready still pulses.
- slv_valid still high in the IDLE cycle after RESP is a new transaction.
- slv_rdata holds its last value outside RESP.

## Timing
- Reset values:
  - FSM = IDLE, slv_ready = 0, slv_rdata = 4'h0, bus_out = 5'h0.
  - All 16 registers = 4'h0, wait counter = 0.
- Reset asserted mid-transaction: the transaction is dropped with no ready pulse and no register write. The FSM is in IDLE on the first edge after reset deasserts.
- Latency from the acceptance edge to slv_ready high: 1 + WAIT_CYC cycles with the macro, 1 cycle without.
- Maximum throughput with valid held high:
  - one transaction per 2 + WAIT_CYC cycles with the macro;
  - one transaction per 2 cycles without it.
- A read issued right after a write to the same address returns the new value; there is no hazard because transactions never overlap.

## Configuration
- SLAVE_REG_WAIT_EN defined: the WAIT state and wait counter are compiled in, and WAIT_CYC sets the wait states.
- SLAVE_REG_WAIT_EN undefined: WAIT and the counter are removed and WAIT_CYC is ignored. The FSM is IDLE to RESP to IDLE, with a fixed 1-cycle latency.

## Test plan
- Reset check: with reset high, drive slv_valid=1, we=1, addr=3, wdata=4'h5.
  - Required: slv_ready never asserts and bus_out stays 0.
  - After reset releases, a read of addr 3 returns 4'h0.
- Write then read, macro on, WAIT_CYC=2: write addr 2, data 4'hc.
  - Required: ready pulses exactly 3 cycles after acceptance, with rdata=4'hc.
  - A following read of addr 2 returns 4'hc, and bus_out = 2.
- ID register: write 4'h3 to addr 15, then read addr 15.
  - Required: both responses return 4'ha.
  - Reads of addr 0..14 afterwards are all 4'h0.
- Back-to-back, macro off: hold valid high for 10 cycles.
  - Required: ready is high on every second cycle (5 pulses) and bus_out = 5.
- Mid-operation reset, macro on, WAIT_CYC=4: accept a write of 4'h9 to addr 7, then assert reset 2 cycles later.
  - Required: no ready pulse, and a subsequent read of addr 7 returns 4'h0.
- Counter wrap: complete 33 transactions.
  - Required: bus_out reads 31 after the 31st, 0 after the 32nd and 1 after the 33rd.

Source files
------------

// File: rtl/slave_reg_responder.sv
// slave_reg_responder
//
// Target end of the slv_* valid/ready bus. Holds a 16 x 4-bit register file,
// accepts one read or write per transaction, optionally inserts wait states,
// then returns a single-cycle slv_ready pulse carrying the response data.
// bus_out counts completed transactions modulo 32.
//
// Build option:
//   SLAVE_REG_WAIT_EN  when defined, compiles in the WAIT state and the wait
//                      counter; WAIT_CYC then sets the number of wait states.
//                      When undefined the FSM is IDLE -> RESP -> IDLE and
//                      WAIT_CYC is ignored.
//
// Parameters:
//   WAIT_CYC   wait states between acceptance and response (0..15)
//   ID_VAL     constant returned for any access to address 4'hf
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous active-high reset
//   slv_valid  request valid, held by the master until it sees slv_ready
//   slv_we     1 = write, 0 = read (sampled at acceptance)
//   slv_addr   register index (sampled at acceptance)
//   slv_wdata  write data (sampled at acceptance)
//   slv_rdata  response data, meaningful while slv_ready is high
//   slv_ready  single-cycle response pulse
//   bus_out    completed-transaction count, modulo 32

module slave_reg_responder #(
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [3:0]  ID_VAL   = 4'ha
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       slv_valid,
    input  logic       slv_we,
    input  logic [3:0] slv_addr,
    input  logic [3:0] slv_wdata,
    output logic [3:0] slv_rdata,
    output logic       slv_ready,
    output logic [4:0] bus_out
);

    localparam logic [3:0] IdAddr = 4'hf;

`ifdef SLAVE_REG_WAIT_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StResp = 2'd2
    } state_e;
`endif

    state_e state_q, state_d;

    logic [3:0] regs_q [16];

    // Request fields as seen on the edge that enters RESP.
    logic       cur_we;
    logic [3:0] cur_addr;
    logic [3:0] cur_wdata;
    logic [3:0] resp_data;
    logic       accept;
    logic       enter_resp;

    assign accept     = (state_q == StIdle) && slv_valid;
    assign enter_resp = (state_d == StResp) && (state_q != StResp);

`ifdef SLAVE_REG_WAIT_EN
    localparam logic [3:0] WaitLoad = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    logic       req_we_q;
    logic [3:0] req_addr_q;
    logic [3:0] req_wdata_q;
    logic [3:0] wait_cnt_q;

    // With zero wait states RESP is entered on the acceptance edge itself, so
    // the live bus fields must be used there; otherwise the latched copy.
    always_comb begin
        cur_we    = req_we_q;
        cur_addr  = req_addr_q;
        cur_wdata = req_wdata_q;
        if (state_q == StIdle) begin
            cur_we    = slv_we;
            cur_addr  = slv_addr;
            cur_wdata = slv_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= 4'h0;
            req_wdata_q <= 4'h0;
            wait_cnt_q  <= 4'h0;
        end else begin
            if (accept) begin
                req_we_q    <= slv_we;
                req_addr_q  <= slv_addr;
                req_wdata_q <= slv_wdata;
                wait_cnt_q  <= WaitLoad;
            end else if ((state_q == StWait) && (wait_cnt_q != 4'h0)) begin
                wait_cnt_q <= wait_cnt_q - 4'h1;
            end
        end
    end
`else
    // Without wait states RESP is always entered on the acceptance edge, so
    // the live bus fields are the accepted request.
    assign cur_we    = slv_we;
    assign cur_addr  = slv_addr;
    assign cur_wdata = slv_wdata;

    logic unused_wait_cyc;
    assign unused_wait_cyc = ^WAIT_CYC;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (slv_valid) begin
`ifdef SLAVE_REG_WAIT_EN
                    if (WAIT_CYC > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = StResp;
                    end
`else
                    state_d = StResp;
`endif
                end
            end
`ifdef SLAVE_REG_WAIT_EN
            StWait: begin
                if (wait_cnt_q == 4'h0) begin
                    state_d = StResp;
                end
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response data: ID register, echoed write data, or register contents.
    always_comb begin
        resp_data = regs_q[cur_addr];
        if (cur_addr == IdAddr) begin
            resp_data = ID_VAL;
        end else if (cur_we) begin
            resp_data = cur_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            slv_ready <= 1'b0;
            slv_rdata <= 4'h0;
            bus_out   <= 5'h0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else begin
            state_q   <= state_d;
            // RESP lasts exactly one cycle, so this yields a one-cycle pulse.
            slv_ready <= (state_d == StResp);
            if (enter_resp) begin
                slv_rdata <= resp_data;
                if (cur_we && (cur_addr != IdAddr)) begin
                    regs_q[cur_addr] <= cur_wdata;
                end
            end
            if (state_q == StResp) begin
                bus_out <= bus_out + 5'd1;
            end
        end
    end

endmodule
